// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
//   Shared timing definitions for the DE-synchronised RGB565 panel path:
//   horizontal/vertical SYNC/BACK/DISP/FRONT/TOTAL figures used by the
//   panel driver, the DE-low gap that marks vertical blanking, the
//   receiver FSM state type and a saturating coordinate increment.
package lcd_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned LCD_H_SYNC  = 128;
    localparam int unsigned LCD_H_BACK  = 88;
    localparam int unsigned LCD_H_DISP  = 800;
    localparam int unsigned LCD_H_FRONT = 40;
    localparam int unsigned LCD_H_TOTAL = LCD_H_SYNC + LCD_H_BACK + LCD_H_DISP + LCD_H_FRONT;

    // Vertical timing, in lines
    localparam int unsigned LCD_V_SYNC  = 2;
    localparam int unsigned LCD_V_BACK  = 33;
    localparam int unsigned LCD_V_DISP  = 480;
    localparam int unsigned LCD_V_FRONT = 10;
    localparam int unsigned LCD_V_TOTAL = LCD_V_SYNC + LCD_V_BACK + LCD_V_DISP + LCD_V_FRONT;

    // DE-low run length that separates frames; longer than the horizontal
    // blank (H_TOTAL - H_DISP) and shorter than the vertical blank.
    localparam int unsigned LCD_VGAP_MIN = 2048;

    // Counter widths
    localparam int unsigned GAP_W = 12;
    localparam int unsigned CRD_W = 11;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2,
        HBLANK = 2'd3
    } rx_state_t;

    // Coordinates stick at all-ones instead of wrapping.
    function automatic logic [CRD_W-1:0] sat_inc11(input logic [CRD_W-1:0] v);
        return (v == '1) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/lcd_de_receiver_if.sv
// lcd_de_receiver_if
//   Bundle of the sampled panel stream and the capture/status outputs of
//   lcd_de_receiver.
//   slave  : receiver side - lcd_de/lcd_rgb in, pixel and status out.
//   master : source/consumer side - drives the stream, observes results.
interface lcd_de_receiver_if;

    logic        lcd_de;
    logic [15:0] lcd_rgb;

    logic        pix_valid;
    logic [15:0] pix_data;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        frame_start;
    logic        frame_done;
    logic [10:0] last_line_len;
    logic [10:0] frame_lines;
    logic        err_hsize;
    logic        err_vsize;
    logic        locked;

    modport slave (
        input  lcd_de, lcd_rgb,
        output pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done,
               last_line_len, frame_lines, err_hsize, err_vsize, locked
    );

    modport master (
        output lcd_de, lcd_rgb,
        input  pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done,
               last_line_len, frame_lines, err_hsize, err_vsize, locked
    );

endinterface

// File: rtl/lcd_gap_counter.sv
// lcd_gap_counter
//   Counts consecutive DE-low samples (12-bit, saturating at 4095, cleared
//   by DE = 1) and flags the sample that brings the run to THRESH.
//   clk_i  : pixel clock
//   rst_ni : asynchronous active-low reset
//   de_i   : sampled data enable
//   hit_o  : the current DE-low sample makes the run length >= THRESH
module lcd_gap_counter
    import lcd_timing_pkg::*;
#(
    parameter int unsigned THRESH = LCD_VGAP_MIN
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic de_i,
    output logic hit_o
);

    localparam logic [GAP_W-1:0] THR_M1 = GAP_W'(THRESH - 1);

    logic [GAP_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (de_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looks at the registered run plus the sample being taken now, so the
    // FSM reacts on the very edge of the THRESH-th low sample.
    assign hit_o = !de_i && (cnt_q >= THR_M1);

endmodule

// File: rtl/lcd_de_receiver.sv
// lcd_de_receiver
//   Receive-side timing decoder for the DE-only RGB565 panel stream.
//   Recovers line/frame structure from DE, emits pixels tagged with (x,y),
//   measures line length and line count, flags size errors and reports lock.
//   lcd_clk   : pixel clock, rising-edge sampling
//   sys_rst_n : asynchronous active-low reset
//   lcd_bus   : slave side of lcd_de_receiver_if
//               in  : lcd_de, lcd_rgb
//               out : pix_valid/pix_data/pix_x/pix_y, frame_start,
//                     frame_done, last_line_len, frame_lines,
//                     err_hsize, err_vsize, locked (all registered)
module lcd_de_receiver
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_DISP   = LCD_H_DISP,
    parameter int unsigned V_DISP   = LCD_V_DISP,
    parameter int unsigned VGAP_MIN = LCD_VGAP_MIN
) (
    input  logic               lcd_clk,
    input  logic               sys_rst_n,
    lcd_de_receiver_if.slave   lcd_bus
);

    localparam logic [CRD_W-1:0] H_DISP_W = CRD_W'(H_DISP);
    localparam logic [CRD_W-1:0] V_DISP_W = CRD_W'(V_DISP);

    rx_state_t state_q, state_d;

    logic [CRD_W-1:0] x_q, x_d;
    logic [CRD_W-1:0] y_q, y_d;
    logic [CRD_W-1:0] lines_q, lines_d;
    logic             ferr_q, ferr_d;

    logic             pix_valid_q, pix_valid_d;
    logic [15:0]      pix_data_q, pix_data_d;
    logic [CRD_W-1:0] pix_x_q, pix_x_d;
    logic [CRD_W-1:0] pix_y_q, pix_y_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic [CRD_W-1:0] llen_q, llen_d;
    logic [CRD_W-1:0] flines_q, flines_d;
    logic             err_hsize_q, err_hsize_d;
    logic             err_vsize_q, err_vsize_d;
    logic             locked_q, locked_d;

    logic             gap_hit;
    logic             line_end;
    logic             frame_end;

    lcd_gap_counter #(
        .THRESH (VGAP_MIN)
    ) u_gap (
        .clk_i  (lcd_clk),
        .rst_ni (sys_rst_n),
        .de_i   (lcd_bus.lcd_de),
        .hit_o  (gap_hit)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        lines_d       = lines_q;
        ferr_d        = ferr_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        llen_d        = llen_q;
        flines_d      = flines_q;
        err_hsize_d   = 1'b0;
        err_vsize_d   = 1'b0;
        locked_d      = locked_q;
        line_end      = 1'b0;
        frame_end     = 1'b0;

        unique case (state_q)
            SEARCH: begin
                if (gap_hit) begin
                    state_d = VBLANK;
                end
            end

            VBLANK: begin
                if (lcd_bus.lcd_de) begin
                    state_d       = ACTIVE;
                    pix_valid_d   = 1'b1;
                    pix_data_d    = lcd_bus.lcd_rgb;
                    pix_x_d       = '0;
                    pix_y_d       = '0;
                    frame_start_d = 1'b1;
                    x_d           = 11'd1;
                    y_d           = '0;
                    lines_d       = '0;
                    ferr_d        = 1'b0;
                end
            end

            ACTIVE: begin
                if (lcd_bus.lcd_de) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = lcd_bus.lcd_rgb;
                    pix_x_d     = x_q;
                    pix_y_d     = y_q;
                    x_d         = sat_inc11(x_q);
                end else begin
                    line_end = 1'b1;
                    // Only reachable with a one-sample gap threshold: the
                    // line end and frame end then share this edge.
                    if (gap_hit) begin
                        state_d   = VBLANK;
                        frame_end = 1'b1;
                    end else begin
                        state_d = HBLANK;
                    end
                end
            end

            HBLANK: begin
                if (lcd_bus.lcd_de) begin
                    state_d     = ACTIVE;
                    y_d         = sat_inc11(y_q);
                    pix_valid_d = 1'b1;
                    pix_data_d  = lcd_bus.lcd_rgb;
                    pix_x_d     = '0;
                    pix_y_d     = sat_inc11(y_q);
                    x_d         = 11'd1;
                end else if (gap_hit) begin
                    state_d   = VBLANK;
                    frame_end = 1'b1;
                end
            end

            default: state_d = SEARCH;
        endcase

        // x_q holds the number of pixels taken on this line (saturated),
        // which is exactly the line length at DE fall.
        if (line_end) begin
            llen_d  = x_q;
            lines_d = sat_inc11(lines_q);
            if (x_q != H_DISP_W) begin
                err_hsize_d = 1'b1;
                ferr_d      = 1'b1;
                locked_d    = 1'b0;
            end
        end

        // Evaluated after the line-end block so a same-edge width error is
        // already folded into ferr_d and keeps locked low.
        if (frame_end) begin
            frame_done_d = 1'b1;
            flines_d     = lines_d;
            if (!ferr_d && (lines_d == V_DISP_W)) begin
                locked_d = 1'b1;
            end else begin
                locked_d = 1'b0;
                if (lines_d != V_DISP_W) begin
                    err_vsize_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= SEARCH;
            x_q           <= '0;
            y_q           <= '0;
            lines_q       <= '0;
            ferr_q        <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            llen_q        <= '0;
            flines_q      <= '0;
            err_hsize_q   <= 1'b0;
            err_vsize_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            lines_q       <= lines_d;
            ferr_q        <= ferr_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            llen_q        <= llen_d;
            flines_q      <= flines_d;
            err_hsize_q   <= err_hsize_d;
            err_vsize_q   <= err_vsize_d;
            locked_q      <= locked_d;
        end
    end

    assign lcd_bus.pix_valid     = pix_valid_q;
    assign lcd_bus.pix_data      = pix_data_q;
    assign lcd_bus.pix_x         = pix_x_q;
    assign lcd_bus.pix_y         = pix_y_q;
    assign lcd_bus.frame_start   = frame_start_q;
    assign lcd_bus.frame_done    = frame_done_q;
    assign lcd_bus.last_line_len = llen_q;
    assign lcd_bus.frame_lines   = flines_q;
    assign lcd_bus.err_hsize     = err_hsize_q;
    assign lcd_bus.err_vsize     = err_vsize_q;
    assign lcd_bus.locked        = locked_q;

endmodule

// File: tb/tb_lcd_de_receiver.sv
// tb_lcd_de_receiver
//   Directed bench for lcd_de_receiver using a scaled-down raster
//   (16 pixels x 6 lines, 64-sample frame gap, 8-sample line blank) so that
//   whole frames fit in a short run. The 3000-sample DE-high line exercises
//   the 2047 coordinate saturation at full width.
module tb_lcd_de_receiver;

    localparam int unsigned H        = 16;
    localparam int unsigned V        = 6;
    localparam int unsigned GAP      = 64;
    localparam int unsigned HB       = 8;
    localparam int unsigned VB_EXTRA = 20;
    localparam int unsigned NONE     = 9999;

    logic        lcd_clk = 1'b0;
    logic        sys_rst_n;
    int unsigned tests  = 0;
    int unsigned fails  = 0;
    int unsigned pv_cnt = 0;

    lcd_de_receiver_if bus ();

    lcd_de_receiver #(
        .H_DISP   (H),
        .V_DISP   (V),
        .VGAP_MIN (GAP)
    ) dut (
        .lcd_clk   (lcd_clk),
        .sys_rst_n (sys_rst_n),
        .lcd_bus   (bus)
    );

    always #5 lcd_clk = ~lcd_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample, let it be clocked in, settle 1 time unit past the edge.
    task automatic cyc(input logic de, input logic [15:0] rgb);
        bus.lcd_de  = de;
        bus.lcd_rgb = rgb;
        @(posedge lcd_clk);
        #1;
        if (bus.pix_valid === 1'b1) pv_cnt++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pix_valid"},   32'(bus.pix_valid),     32'd0);
        chk({tag, "_pix_data"},    32'(bus.pix_data),      32'd0);
        chk({tag, "_pix_x"},       32'(bus.pix_x),         32'd0);
        chk({tag, "_pix_y"},       32'(bus.pix_y),         32'd0);
        chk({tag, "_frame_start"}, 32'(bus.frame_start),   32'd0);
        chk({tag, "_frame_done"},  32'(bus.frame_done),    32'd0);
        chk({tag, "_llen"},        32'(bus.last_line_len), 32'd0);
        chk({tag, "_flines"},      32'(bus.frame_lines),   32'd0);
        chk({tag, "_err_hsize"},   32'(bus.err_hsize),     32'd0);
        chk({tag, "_err_vsize"},   32'(bus.err_vsize),     32'd0);
        chk({tag, "_locked"},      32'(bus.locked),        32'd0);
    endtask

    // One line of n pixels with rgb = {y[4:0], x[10:0]}, then HB low samples.
    task automatic send_line(input int unsigned y, input int unsigned n);
        logic [15:0] rgb;
        logic [10:0] xs;
        int unsigned lexp;
        for (int unsigned x = 0; x < n; x++) begin
            xs  = (x > 2047) ? 11'd2047 : 11'(x);
            rgb = {5'(y), 11'(x)};
            cyc(1'b1, rgb);
            chk("pix_valid",   32'(bus.pix_valid),   32'd1);
            chk("pix_x",       32'(bus.pix_x),       32'(xs));
            chk("pix_y",       32'(bus.pix_y),       32'(y));
            chk("pix_data",    32'(bus.pix_data),    32'(rgb));
            chk("frame_start", 32'(bus.frame_start), (x == 0 && y == 0) ? 32'd1 : 32'd0);
        end
        lexp = (n > 2047) ? 2047 : n;
        cyc(1'b0, '0);
        chk("line_end_pix_valid", 32'(bus.pix_valid),     32'd0);
        chk("err_hsize",          32'(bus.err_hsize),     (lexp != H) ? 32'd1 : 32'd0);
        chk("last_line_len",      32'(bus.last_line_len), 32'(lexp));
        if (lexp != H) chk("locked_after_hsize", 32'(bus.locked), 32'd0);
        cyc(1'b0, '0);
        chk("err_hsize_pulse", 32'(bus.err_hsize), 32'd0);
        repeat (HB - 2) cyc(1'b0, '0);
    endtask

    // Remaining DE-low samples up to and past the frame gap threshold.
    // HB lows were already sent after the last line.
    task automatic end_frame(input int unsigned e_flines, input logic e_vsize,
                             input logic e_locked, input int unsigned e_llen,
                             input int unsigned e_pix);
        repeat (GAP - HB - 1) cyc(1'b0, '0);
        chk("frame_done_early", 32'(bus.frame_done), 32'd0);
        cyc(1'b0, '0);
        chk("frame_done",    32'(bus.frame_done),    32'd1);
        chk("frame_lines",   32'(bus.frame_lines),   32'(e_flines));
        chk("err_vsize",     32'(bus.err_vsize),     32'(e_vsize));
        chk("locked",        32'(bus.locked),        32'(e_locked));
        chk("frame_llen",    32'(bus.last_line_len), 32'(e_llen));
        chk("pixel_count",   32'(pv_cnt),            32'(e_pix));
        cyc(1'b0, '0);
        chk("frame_done_pulse", 32'(bus.frame_done), 32'd0);
        chk("err_vsize_pulse",  32'(bus.err_vsize),  32'd0);
        repeat (VB_EXTRA) cyc(1'b0, '0);
    endtask

    task automatic send_frame(input int unsigned nlines, input int unsigned short_y,
                              input int unsigned short_len, input logic e_vsize,
                              input logic e_locked, input int unsigned e_llen,
                              input int unsigned e_pix);
        pv_cnt = 0;
        for (int unsigned y = 0; y < nlines; y++) begin
            send_line(y, (y == short_y) ? short_len : H);
        end
        end_frame(nlines, e_vsize, e_locked, e_llen, e_pix);
    endtask

    initial begin
        // Reset state
        sys_rst_n   = 1'b0;
        bus.lcd_de  = 1'b0;
        bus.lcd_rgb = '0;
        #23;
        check_zero("reset");
        @(posedge lcd_clk);
        #1;
        sys_rst_n = 1'b1;

        // Pixels before the first frame gap are ignored
        repeat (5) begin
            cyc(1'b1, 16'hABCD);
            chk("search_pix_valid", 32'(bus.pix_valid), 32'd0);
        end
        repeat (GAP + 10) cyc(1'b0, '0);
        chk("search_frame_done", 32'(bus.frame_done), 32'd0);

        // Two nominal frames: 16x6 = 96 pixels each
        send_frame(V, NONE, H, 1'b0, 1'b1, H, 96);
        send_frame(V, NONE, H, 1'b0, 1'b1, H, 96);

        // Short line on row 2 (15 pixels), then recovery
        send_frame(V, 2, H - 1, 1'b0, 1'b0, H, 95);
        send_frame(V, NONE, H, 1'b0, 1'b1, H, 96);

        // Short frame: 5 lines, then recovery
        send_frame(V - 1, NONE, H, 1'b1, 1'b0, H, 80);
        send_frame(V, NONE, H, 1'b0, 1'b1, H, 96);

        // Reset mid-line at x = 9 (10 pixels taken), y = 3
        for (int unsigned y = 0; y < 3; y++) send_line(y, H);
        for (int unsigned x = 0; x < 10; x++) cyc(1'b1, {5'd3, 11'(x)});
        chk("midline_pix_x", 32'(bus.pix_x), 32'd9);
        chk("midline_pix_y", 32'(bus.pix_y), 32'd3);
        sys_rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(posedge lcd_clk);
        #1;
        sys_rst_n = 1'b1;
        repeat (5) begin
            cyc(1'b1, 16'h1234);
            chk("post_rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        end
        repeat (GAP - 1) cyc(1'b0, '0);
        cyc(1'b1, 16'h5555);
        chk("short_gap_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("short_gap_frame_done", 32'(bus.frame_done), 32'd0);
        repeat (GAP) cyc(1'b0, '0);
        chk("post_rst_frame_done", 32'(bus.frame_done), 32'd0);
        send_frame(V, NONE, H, 1'b0, 1'b1, H, 96);

        // DE stuck high for 3000 samples: x saturates at 2047
        send_frame(1, 0, 3000, 1'b1, 1'b0, 2047, 3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_de_receiver.md
# lcd_de_receiver

Receive-side timing decoder for the DE-synchronised RGB565 panel interface. It samples the `lcd_de` and `lcd_rgb` stream produced by the panel driver, with HS and VS held high. From DE alone it recovers line and frame structure and emits pixels tagged with coordinates. It also measures the active width and height and flags timing violations. It serves as the loopback checker and capture front end for the display path, and can feed a frame-buffer writer or an on-FPGA self-test.

## Interface
Parameters:
- `H_DISP`, 800: expected active pixels per line.
- `V_DISP`, 480: expected active lines per frame.
- `VGAP_MIN`, 2048: consecutive DE-low cycles that mark vertical blanking. It must exceed the horizontal blank (256) and be less than the vertical blank (45 × 1056).

Ports:
- `lcd_clk`  in  1  pixel clock; all sampling is on the rising edge.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `lcd_de`  in  1  data enable.
- `lcd_rgb`  in  16  RGB565 data; valid while `lcd_de` = 1.
- `pix_valid`  out  1  captured pixel strobe.
- `pix_data`  out  16  captured pixel.
- `pix_x`  out  11  column of `pix_data`, 0-based.
- `pix_y`  out  11  row of `pix_data`, 0-based.
- `frame_start`  out  1  one-cycle pulse coincident with the pixel at (0,0).
- `frame_done`  out  1  one-cycle pulse when vertical blanking is detected after a frame.
- `last_line_len`  out  11  length of the most recently completed line.
- `frame_lines`  out  11  number of lines in the last completed frame.
- `err_hsize`  out  1  one-cycle pulse when a line length ≠ `H_DISP`.
- `err_vsize`  out  1  one-cycle pulse with `frame_done` when the line count ≠ `V_DISP`.
- `locked`  out  1  set after an error-free frame; cleared on any error.

## Operation
- The FSM has four states:
  - `SEARCH`: the reset state. Pixels are ignored. Go to `VBLANK` when `gap_cnt` reaches `VGAP_MIN`.
  - `VBLANK`: on sampled DE = 1, go to `ACTIVE`, with x = 0, y = 0 and the frame error flag cleared.
  - `ACTIVE`: each DE = 1 sample emits a pixel and increments x. On DE = 0, go to `HBLANK`, latch `last_line_len` = x, increment the line count, and check the width.
  - `HBLANK`: on DE = 1, go to `ACTIVE` with x = 0 and y incremented. If `gap_cnt` reaches `VGAP_MIN`, go to `VBLANK`, pulse `frame_done`, latch `frame_lines`, and check the height.
- `gap_cnt` (12 bits) counts consecutive DE-low samples. It is cleared on DE = 1 and saturates at 4095.
- The x and y counters are 11 bits and saturate at 2047; they never wrap. A saturated line length ≠ `H_DISP`, so it produces an error.
- `err_hsize` sets the frame error flag and clears `locked`.
- At `frame_done`:
  - If the flag is clear and `frame_lines` = `V_DISP`, set `locked`.
  - Otherwise pulse `err_vsize` if the count ≠ `V_DISP`, and clear `locked`.
- When the frame-end check is in the same cycle as a line-end width error, the error wins and `locked` stays 0.
- Reset, including reset mid-line, returns the block to `SEARCH`. A partial frame is never reported.

## Timing
- Every output is registered. Reset value is 0 for all outputs.
- Pixel latency is 1: DE and RGB sampled at edge n give `pix_valid`, `pix_data`, `pix_x` and `pix_y` valid after edge n+1.
- `frame_start` appears with the first pixel of each frame captured from `VBLANK`.
- Width check: on the cycle after the first DE = 0 sample, `err_hsize` and the updated `last_line_len` appear.
- Height check: `frame_done`, `err_vsize`, `frame_lines` and `locked` all update on the cycle after the `VGAP_MIN`-th consecutive DE-low sample.
- There is no backpressure; the downstream consumer must accept one pixel per clock.

## Structure
- Shared package `lcd_timing_pkg`:
  - the H/V timing constants (SYNC/BACK/DISP/FRONT/TOTAL) used by the driver;
  - `VGAP_MIN`;
  - the FSM state enum.
- Sub-module `lcd_gap_counter`: the saturating DE-low counter with a threshold-reached output.
- The FSM, coordinate counters and checker live in the top module.

## Test plan
- **Nominal stream.** Drive the standard 1056×525 DE pattern, starting from reset. Two `frame_done` pulses are required:
  - 384000 `pix_valid` strobes between them;
  - `frame_lines` = 480 and `last_line_len` = 800;
  - no error pulses, and `locked` = 1 after the first `frame_done`.
- **Pixel data and coordinates.** Drive `lcd_rgb` = {y[4:0], x[10:0]}. Every captured `pix_data` must equal {`pix_y`[4:0], `pix_x`} with 1-cycle latency. `frame_start` must coincide with (0,0) only.
- **Short line.** Make line 10 carry 799 pixels. Required: `err_hsize` pulse, `last_line_len` = 799, `locked` = 0, and the next error-free frame sets `locked` = 1 again.
- **Short frame.** Send a 479-line frame. Required: `frame_done` with `err_vsize` = 1, `frame_lines` = 479, `locked` = 0.
- **Reset mid-line.** Assert reset at x = 300, y = 100. Required: all outputs 0 immediately, and no `pix_valid` until 2048 DE-low cycles have elapsed and DE rises again.
- **DE stuck high.** Hold DE high for 3000 cycles. Required: `pix_x` saturates at 2047, then on DE fall `err_hsize` pulses and `last_line_len` = 2047.
